// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared definitions for the two-port on-chip memory arbiter.
// Holds the port-index type, default bus widths and priority-mode constants,
// plus the tie-break helper used by the grant logic.
package onchip_mem_arbiter_pkg;

  // Requester index: port 0 is instruction fetch, port 1 is data.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 32;

  // Priority modes selectable through FIXED_PRIO.
  localparam int PRIO_ROUND_ROBIN = 0;
  localparam int PRIO_FIXED_P1    = 1;

  // Winner of a tie: fixed mode always favours port 1; round-robin favours
  // whichever port was not granted most recently.
  function automatic port_t pick_tie(input int mode, input port_t last_grant);
    port_t winner;
    if (mode == PRIO_FIXED_P1) begin
      winner = PORT1;
    end else if (last_grant == PORT1) begin
      winner = PORT0;
    end else begin
      winner = PORT1;
    end
    return winner;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input arbiter: combinational grant decision plus the last_grant
// register that drives round-robin fairness.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   active0/active1   requester N wants the memory this cycle
//   grant0/grant1     one-hot (or zero) grant, valid in the same cycle
module rr_arbiter2
  import onchip_mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = PRIO_ROUND_ROBIN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active0,
  input  logic active1,
  output logic grant0,
  output logic grant1
);

  port_t last_grant;
  port_t tie_winner;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    tie_winner = pick_tie(FIXED_PRIO, last_grant);
    if (!reset_n) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else if (active0 && active1) begin
      if (tie_winner == PORT0) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else if (active0) begin
      grant0 = 1'b1;
    end else if (active1) begin
      grant1 = 1'b1;
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // Remember the most recent winner; reset value makes port 0 win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PORT1;
    end else if (grant0) begin
      last_grant <= PORT0;
    end else if (grant1) begin
      last_grant <= PORT1;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Arbitrates an instruction-fetch port (0) and a data port (1) onto one
// single-port synchronous memory with a 1-cycle read latency.
// Ports:
//   clk, reset_n                 clock and asynchronous active-low reset
//   pN_address/byteenable/
//   pN_read/write/writedata      requester N transfer request
//   pN_waitrequest               request not accepted this cycle
//   pN_readdata/readdatavalid    read return to requester N
//   mem_*                        memory-side request fields and controls
//   mem_readdata                 memory output, one cycle after a read
module onchip_mem_arbiter
  import onchip_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIXED_PRIO = PRIO_ROUND_ROBIN
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   p0_address,
  input  logic [DATA_W/8-1:0] p0_byteenable,
  input  logic                p0_read,
  input  logic                p0_write,
  input  logic [DATA_W-1:0]   p0_writedata,
  output logic                p0_waitrequest,
  output logic [DATA_W-1:0]   p0_readdata,
  output logic                p0_readdatavalid,
  input  logic [ADDR_W-1:0]   p1_address,
  input  logic [DATA_W/8-1:0] p1_byteenable,
  input  logic                p1_read,
  input  logic                p1_write,
  input  logic [DATA_W-1:0]   p1_writedata,
  output logic                p1_waitrequest,
  output logic [DATA_W-1:0]   p1_readdata,
  output logic                p1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic  active0;
  logic  active1;
  logic  grant0;
  logic  grant1;
  logic  issue_read;
  port_t issue_owner;
  logic  pending;
  port_t owner;

  assign active0 = p0_read | p0_write;
  assign active1 = p1_read | p1_write;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .active0 (active0),
    .active1 (active1),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  // A granted transfer completes in its grant cycle, so waiting is just active-but-not-granted.
  assign p0_waitrequest = active0 & ~grant0;
  assign p1_waitrequest = active1 & ~grant1;
  assign mem_chipselect = grant0 | grant1;
  assign mem_clken      = 1'b1;

  // Route the granted port onto the memory bus; idle bus fields are zero.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (grant0) begin
      mem_address    = p0_address;
      mem_byteenable = p0_byteenable;
      mem_writedata  = p0_writedata;
      mem_write      = p0_write;
    end else if (grant1) begin
      mem_address    = p1_address;
      mem_byteenable = p1_byteenable;
      mem_writedata  = p1_writedata;
      mem_write      = p1_write;
    end else begin
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      mem_write      = 1'b0;
    end
  end

  // Read+write together counts as a write, so only a pure read expects a return.
  always_comb begin
    issue_read  = 1'b0;
    issue_owner = PORT0;
    if (grant0) begin
      issue_read  = p0_read & ~p0_write;
      issue_owner = PORT0;
    end else if (grant1) begin
      issue_read  = p1_read & ~p1_write;
      issue_owner = PORT1;
    end else begin
      issue_read  = 1'b0;
      issue_owner = PORT0;
    end
  end

  // One-deep return tracker: memory latency is exactly one cycle, so a new
  // read issued every cycle just overwrites the previous owner in order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      owner   <= PORT0;
    end else begin
      pending <= issue_read;
      if (issue_read) begin
        owner <= issue_owner;
      end
    end
  end

  // Steer memory output to the owning port; non-owners see zero.
  always_comb begin
    p0_readdatavalid = 1'b0;
    p1_readdatavalid = 1'b0;
    p0_readdata      = '0;
    p1_readdata      = '0;
    if (pending && (owner == PORT0)) begin
      p0_readdatavalid = 1'b1;
      p0_readdata      = mem_readdata;
    end else if (pending && (owner == PORT1)) begin
      p1_readdatavalid = 1'b1;
      p1_readdata      = mem_readdata;
    end else begin
      p0_readdatavalid = 1'b0;
      p1_readdatavalid = 1'b0;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: a round-robin instance with a
// behavioural memory and read-return scoreboard, plus a fixed-priority
// instance used for the starvation scenario.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  p0_address, p1_address;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [31:0] p0_writedata, p1_writedata;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic [7:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;

  // fixed-priority instance signals
  logic        f_p0_read, f_p1_read, f_no_write;
  logic        f_p0_waitrequest, f_p1_waitrequest;
  logic [31:0] f_p0_readdata, f_p1_readdata;
  logic        f_p0_readdatavalid, f_p1_readdatavalid;
  logic [7:0]  f_mem_address;
  logic [3:0]  f_mem_byteenable;
  logic [31:0] f_mem_writedata;
  logic        f_mem_chipselect, f_mem_write, f_mem_clken;
  logic [31:0] f_mem_readdata;

  logic [31:0] mem [256];

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
    .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
    .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
    .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
    .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  onchip_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .reset_n(reset_n),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(f_p0_read),
    .p0_write(f_no_write), .p0_writedata(p0_writedata), .p0_waitrequest(f_p0_waitrequest),
    .p0_readdata(f_p0_readdata), .p0_readdatavalid(f_p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(f_p1_read),
    .p1_write(f_no_write), .p1_writedata(p1_writedata), .p1_waitrequest(f_p1_waitrequest),
    .p1_readdata(f_p1_readdata), .p1_readdatavalid(f_p1_readdatavalid),
    .mem_address(f_mem_address), .mem_byteenable(f_mem_byteenable),
    .mem_writedata(f_mem_writedata), .mem_chipselect(f_mem_chipselect),
    .mem_write(f_mem_write), .mem_clken(f_mem_clken), .mem_readdata(f_mem_readdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous memory model, 1-cycle read latency, byte-lane writes
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  // read-return monitor against the scoreboard
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      check_eq("rdv_missing", 64'd0, 64'd1);
      mon_e = sb.pop_front();
    end
    if (p0_readdatavalid || p1_readdatavalid) begin
      check_eq("rdv_single", 64'(p0_readdatavalid & p1_readdatavalid), 64'd0);
      if (sb.size() == 0) begin
        check_eq("rdv_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("rdv_port", 64'(p1_readdatavalid), 64'(mon_e.port));
        check_eq("rdv_data", 64'(p1_readdatavalid ? p1_readdata : p0_readdata), 64'(mon_e.data));
        check_eq("rdv_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    if (!p0_readdatavalid) check_eq("rd0_idle_zero", 64'(p0_readdata), 64'd0);
    if (!p1_readdatavalid) check_eq("rd1_idle_zero", 64'(p1_readdata), 64'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      mem[8'h20 + k] = 32'h1000 + k;
      mem[8'h30 + k] = 32'h2000 + k;
    end
    mem[8'h05] = 32'hAAAAAAAA;
    mem[8'h03] = 32'h00000011;
    mem_readdata   = 32'h0;
    f_mem_readdata = 32'h0;
    f_no_write = 1'b0;
    f_p0_read = 1'b0; f_p1_read = 1'b0;
    reset_n = 1'b0;
    p0_address = 8'h0; p1_address = 8'h0;
    p0_byteenable = 4'hF; p1_byteenable = 4'hF;
    p0_writedata = 32'h0; p1_writedata = 32'h0;
    p0_write = 1'b0; p1_write = 1'b0;
    p0_read = 1'b1; p1_read = 1'b0;

    // reset state: nothing granted, active port waits
    @(negedge clk);
    check_eq("rst_wait0", 64'(p0_waitrequest), 64'd1);
    check_eq("rst_cs", 64'(mem_chipselect), 64'd0);
    check_eq("rst_mw", 64'(mem_write), 64'd0);
    check_eq("rst_clken", 64'(mem_clken), 64'd1);
    check_eq("rst_addr", 64'(mem_address), 64'd0);
    p0_read = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;

    // contention: alternating grants starting with p0
    for (int i = 0; i < 6; i++) begin
      p0_read = 1'b1; p1_read = 1'b1;
      p0_address = 8'(8'h20 + (i + 1) / 2);
      p1_address = 8'(8'h30 + i / 2);
      if (i % 2 == 0) push_exp(1'b0, 32'(32'h1000 + (i + 1) / 2));
      else            push_exp(1'b1, 32'(32'h2000 + i / 2));
      @(negedge clk);
      check_eq("rr_wait0", 64'(p0_waitrequest), 64'(i % 2 == 1));
      check_eq("rr_wait1", 64'(p1_waitrequest), 64'(i % 2 == 0));
      check_eq("rr_addr", 64'(mem_address),
               (i % 2 == 0) ? 64'(8'h20 + (i + 1) / 2) : 64'(8'h30 + i / 2));
      tick;
    end
    p0_read = 1'b0; p1_read = 1'b0;
    tick;

    // single-port read, 1-cycle latency
    p0_read = 1'b1; p0_address = 8'h10;
    push_exp(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("s_wait0", 64'(p0_waitrequest), 64'd0);
    check_eq("s_cs", 64'(mem_chipselect), 64'd1);
    tick;
    p0_read = 1'b0;
    tick;

    // byte write then read back
    p1_write = 1'b1; p1_address = 8'h05; p1_writedata = 32'h11223344; p1_byteenable = 4'b0100;
    @(negedge clk);
    check_eq("bw_wait1", 64'(p1_waitrequest), 64'd0);
    check_eq("bw_mw", 64'(mem_write), 64'd1);
    check_eq("bw_be", 64'(mem_byteenable), 64'h4);
    check_eq("bw_wd", 64'(mem_writedata), 64'h11223344);
    tick;
    p1_write = 1'b0; p1_read = 1'b1; p1_byteenable = 4'hF;
    push_exp(1'b1, 32'hAA22AAAA);
    tick;
    p1_read = 1'b0;
    tick;

    // same-cycle read (p0, owed the tie) and write (p1) to address 3
    p0_read = 1'b1; p0_address = 8'h03;
    p1_write = 1'b1; p1_address = 8'h03; p1_writedata = 32'h55;
    push_exp(1'b0, 32'h00000011);
    @(negedge clk);
    check_eq("ov_wait0", 64'(p0_waitrequest), 64'd0);
    check_eq("ov_wait1", 64'(p1_waitrequest), 64'd1);
    tick;
    p0_read = 1'b0;
    @(negedge clk);
    check_eq("ov_wait1_next", 64'(p1_waitrequest), 64'd0);
    tick;
    p1_write = 1'b0; p1_read = 1'b1;
    push_exp(1'b1, 32'h00000055);
    tick;
    p1_read = 1'b0;
    tick;

    // read+write together is a write: no return expected
    p0_read = 1'b1; p0_write = 1'b1; p0_address = 8'h06; p0_writedata = 32'h12345678;
    @(negedge clk);
    check_eq("rw_mw", 64'(mem_write), 64'd1);
    tick;
    p0_write = 1'b0;
    push_exp(1'b0, 32'h12345678);
    tick;
    p0_read = 1'b0;
    tick;

    // fixed priority: p1 always wins, p0 starves until p1 drops
    f_p0_read = 1'b1; f_p1_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("fx_wait0", 64'(f_p0_waitrequest), 64'd1);
      check_eq("fx_wait1", 64'(f_p1_waitrequest), 64'd0);
      tick;
    end
    f_p1_read = 1'b0;
    @(negedge clk);
    check_eq("fx_p0_win", 64'(f_p0_waitrequest), 64'd0);
    tick;
    f_p0_read = 1'b0;
    tick;

    // reset in the cycle after a granted read: return is dropped
    p0_read = 1'b1; p0_address = 8'h10;
    tick;
    reset_n = 1'b0; p0_read = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    p0_read = 1'b1; p1_read = 1'b1; p0_address = 8'h10; p1_address = 8'h30;
    push_exp(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("rm_wait0", 64'(p0_waitrequest), 64'd0);
    check_eq("rm_wait1", 64'(p1_waitrequest), 64'd1);
    tick;
    p0_read = 1'b0; p1_read = 1'b0;
    tick;
    tick;

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the shared memory.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 Parameter FIXED_PRIO, default 0; 0 selects round-robin, 1 makes port 1 always win.
REQ-004 The block SHALL have one clock, clk, and an asynchronous active-low reset, reset_n.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 pN_address  in  ADDR_W  word address from requester N, where N is 0 (instruction fetch) or 1 (data).
REQ-008 pN_byteenable  in  DATA_W/8  byte lanes for writes from requester N.
REQ-009 pN_read / pN_write  in  1 each  transfer request from requester N.
REQ-010 pN_writedata  in  DATA_W  write data from requester N.
REQ-011 pN_waitrequest  out  1  high means the request is not accepted this cycle.
REQ-012 pN_readdata  out  DATA_W  read return to requester N.
REQ-013 pN_readdatavalid  out  1  pN_readdata is valid this cycle.
REQ-014 mem_address / mem_byteenable / mem_writedata  out  ADDR_W / DATA_W/8 / DATA_W  memory-side request fields.
REQ-015 mem_chipselect / mem_write / mem_clken  out  1 each  memory-side controls.
REQ-016 mem_readdata  in  DATA_W  memory output; valid 1 cycle after a read is issued.

Function
REQ-017 A requester N is active when (pN_read | pN_write) is high.
REQ-018 The grant SHALL be decided combinationally each cycle; at most one port is granted per cycle.
REQ-019 pN_waitrequest SHALL equal active_N & ~grant_N; a granted transfer completes in the cycle it is granted.
REQ-020 In round-robin mode (FIXED_PRIO=0), a tie goes to the port not granted most recently; last_grant updates only on a grant.
REQ-021 In round-robin mode, a single active requester SHALL be granted every cycle with no idle bubble.
REQ-022 In fixed mode (FIXED_PRIO=1), port 1 wins every tie; port 0 can starve, which is accepted.
REQ-023 The granted port's address, byteenable and writedata SHALL be muxed to mem_*; mem_chipselect = any grant; mem_write = granted pN_write.
REQ-024 If pN_read and pN_write are both high, the access SHALL be treated as a write, and no readdatavalid is produced.
REQ-025 Unselected mem_* data fields SHALL be driven to 0 when no grant is active.
REQ-026 mem_clken SHALL be held at 1.
REQ-027 On a granted read, a pending flag and an owner tag SHALL be registered; the next cycle, pOwner_readdatavalid = 1 and pOwner_readdata = mem_readdata.
REQ-028 pN_readdata SHALL be 0 whenever pN_readdatavalid is low.
REQ-029 Reads are pipelined: back-to-back grants of any mix return in issue order, one per cycle.
REQ-030 A write granted in the cycle after a read SHALL NOT disturb the returning read data.
REQ-031 Read-after-write to the same address on consecutive grants SHALL return the new data, since memory ordering is preserved by serialisation.

Reset
REQ-032 While reset_n is low, grants are forced to 0; pN_waitrequest = active_N; mem_chipselect = mem_write = 0; pending = 0; last_grant = port 1, so port 0 wins the first tie; readdatavalid = 0.
REQ-033 If reset is asserted with a read in flight, the read SHALL be dropped; no readdatavalid appears after reset release.

Structure
REQ-034 A shared package SHALL hold the port-index typedef (PORT0/PORT1), the default ADDR_W/DATA_W, and the priority-mode constants.
REQ-035 One sub-module, rr_arbiter2, SHALL implement the two-input grant logic and the last_grant register; muxing and read-return logic stay in the top level.

Verification
REQ-036 Single port: p0 reads addr 0x10 holding 0xDEADBEEF -> waitrequest 0; p0_readdatavalid=1 with 0xDEADBEEF exactly 1 cycle later; p1 sees no valid.
REQ-037 Contention: both ports read continuously for 6 cycles in round-robin mode -> grants alternate 0,1,0,1,0,1 starting with p0; each readdatavalid is routed to the correct port.
REQ-038 Byte write: p1 writes 0x11223344 to 0x05 with byteenable 4'b0100 over 0xAAAAAAAA -> a later read returns 0xAA22AAAA.
REQ-039 FIXED_PRIO=1: both ports active for 4 cycles -> p1 is granted all 4 and p0_waitrequest stays 1; p0 is granted in the cycle p1 drops.
REQ-040 Reset mid-read: assert reset_n low in the cycle after a granted read -> no readdatavalid at any time; after release, the first tie goes to p0.
REQ-041 Read/write overlap: p0 reads addr 3 while p1 writes addr 3 = 0x55 in the same cycle, round-robin with p0 owed the tie -> p0 receives the old value; p1's next read returns 0x55.
